// File: rtl/spi_pkt_sched_pkg.sv
// rtl/spi_pkt_sched_pkg.sv - shared types, state codes and init table for spi_pkt_sched
package spi_pkt_sched_pkg;

   localparam int INIT_MAX = 8;

   typedef logic [15:0] pkt_t;
   typedef logic [1:0]  state_t;

   localparam state_t ST_INIT = 2'd0;
   localparam state_t ST_ARB  = 2'd1;
   localparam state_t ST_SEND = 2'd2;

   // Display driver bring-up: shutdown off, no decode, intensity, scan limit, test off.
   localparam pkt_t INIT_TABLE [INIT_MAX] = '{
      16'h0C01, 16'h0900, 16'h0A08, 16'h0B07,
      16'h0F00, 16'h0000, 16'h0000, 16'h0000
   };

   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
      return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/spi_pkt_sched_rr_arb.sv
// rtl/spi_pkt_sched_rr_arb.sv - round-robin pointer and first-set search from the pointer
module rr_arb
   import spi_pkt_sched_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   input  logic [2:0]   adv_idx,
   output logic         any,
   output logic [N-1:0] win_oh,
   output logic [2:0]   win_idx
);

   logic [2:0] ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 3'd0;
      end else if (adv) begin
         ptr <= rr_next(adv_idx, N);
      end
   end

   // Two passes: indices at/above the pointer first, then the wrapped ones below it.
   always_comb begin
      any     = 1'b0;
      win_oh  = '0;
      win_idx = 3'd0;
      for (int i = 0; i < N; i++) begin
         if (!any && (3'(i) >= ptr) && req[i]) begin
            any       = 1'b1;
            win_oh[i] = 1'b1;
            win_idx   = 3'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && (3'(i) < ptr) && req[i]) begin
            any       = 1'b1;
            win_oh[i] = 1'b1;
            win_idx   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/spi_pkt_sched.sv
// rtl/spi_pkt_sched.sv - init replay plus round-robin sharing of the SPI packet sender
// Optional periodic init replay: define SPI_PKT_SCHED_REINIT_EN.
module spi_pkt_sched
   import spi_pkt_sched_pkg::*;
#(
   parameter int N_REQ = 2,
`ifdef SPI_PKT_SCHED_REINIT_EN
   parameter int REINIT_PERIOD = 50_000_000,
`endif
   parameter int INIT_LEN = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [16*N_REQ-1:0] req_pkt,
   input  logic [N_REQ-1:0]    req_vld,
   output logic [N_REQ-1:0]    req_rdy,
   output logic [15:0]         m_pkt,
   output logic                m_vld,
   input  logic                m_rdy,
   output logic                init_done,
   output logic [2:0]          grant_id
);

   state_t           state;
   logic [2:0]       idx;
   logic             any;
   logic [N_REQ-1:0] win_oh;
   logic [2:0]       win_idx;
   logic             xfer;
   logic             grant;
   logic             reinit_pend;
   pkt_t             sel_pkt;

   assign xfer    = m_vld & m_rdy;
   assign grant   = !rst && (state == ST_ARB) && any && !reinit_pend;
   assign req_rdy = grant ? win_oh : '0;

   rr_arb #(.N(N_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_vld),
      .adv     ((state == ST_SEND) && xfer),
      .adv_idx (grant_id),
      .any     (any),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_comb begin
      sel_pkt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh[i]) sel_pkt = req_pkt[16*i +: 16];
      end
   end

`ifdef SPI_PKT_SCHED_REINIT_EN
   logic [31:0] reinit_cnt;

   // Counter restarts on the same edge that launches a replay.
   always_ff @(posedge clk) begin
      if (rst) begin
         reinit_cnt  <= 32'd0;
         reinit_pend <= 1'b0;
      end else if ((state == ST_ARB) && reinit_pend) begin
         reinit_cnt  <= 32'd0;
         reinit_pend <= 1'b0;
      end else if (reinit_cnt == 32'(REINIT_PERIOD - 1)) begin
         reinit_cnt  <= 32'd0;
         reinit_pend <= 1'b1;
      end else begin
         reinit_cnt  <= reinit_cnt + 32'd1;
      end
   end
`else
   assign reinit_pend = 1'b0;
`endif

   // m_pkt doubles as the hold register; it only changes when no packet is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         idx       <= 3'd0;
         m_vld     <= 1'b0;
         m_pkt     <= 16'd0;
         init_done <= 1'b0;
         grant_id  <= 3'd0;
      end else begin
         case (state)
            ST_INIT: begin
               if (!m_vld) begin
                  m_vld <= 1'b1;
                  m_pkt <= INIT_TABLE[idx];
               end else if (m_rdy) begin
                  if (idx == 3'(INIT_LEN - 1)) begin
                     idx       <= 3'd0;
                     m_vld     <= 1'b0;
                     init_done <= 1'b1;
                     state     <= ST_ARB;
                  end else begin
                     idx   <= idx + 3'd1;
                     m_pkt <= INIT_TABLE[idx + 3'd1];
                  end
               end
            end
            ST_ARB: begin
               if (reinit_pend) begin
                  idx   <= 3'd0;
                  state <= ST_INIT;
               end else if (any) begin
                  m_vld    <= 1'b1;
                  m_pkt    <= sel_pkt;
                  grant_id <= win_idx;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (m_rdy) begin
                  m_vld <= 1'b0;
                  state <= ST_ARB;
               end
            end
            default: begin
               m_vld <= 1'b0;
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_pkt_sched.md
Name: spi_pkt_sched

Overview:
- Sequencer and arbiter in front of the 16-bit SPI packet sender that drives the display driver chip.
- After reset, it replays a fixed init table of register writes.
- It then shares the single packet sender between N_REQ requesters (sensor and display-update logic) with round-robin arbitration.
- It guarantees one packet in flight at a time, with the packet held stable until the sender accepts it.

Parameters:
- N_REQ, 2, number of requesters; 1..8.
- INIT_LEN, 5, number of init table entries used; 1..INIT_MAX. INIT_MAX is defined in the package.
- REINIT_PERIOD, 50_000_000, clk cycles between init replays; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_pkt  in  16*N_REQ  requester packets; requester i occupies bits [16i+15:16i]
- req_vld  in  N_REQ  requester i has a packet
- req_rdy  out  N_REQ  one-cycle accept pulse to the granted requester
- m_pkt  out  16  packet to the sender
- m_vld  out  1  packet valid to the sender
- m_rdy  in  1  sender ready (high while the sender is idle)
- init_done  out  1  set after the first full init replay
- grant_id  out  3  index of the last granted requester

Behaviour:
- Reset values:
  - req_rdy=0, m_vld=0, m_pkt=0, init_done=0, grant_id=0.
  - Round-robin pointer=0, init index=0, state=INIT.
- States:
  - INIT: m_pkt=INIT_TABLE[idx], m_vld=1.
    - On m_vld&m_rdy with idx<INIT_LEN-1: idx++.
    - On m_vld&m_rdy with idx==INIT_LEN-1: idx=0, init_done<=1, go ARB.
  - ARB: m_vld=0.
    - If any req_vld, choose the first set bit searching from ptr upward, wrapping at N_REQ.
    - Same cycle: assert req_rdy[w]=1, latch req_pkt[w] into the hold register, set grant_id<=w, go SEND.
    - If no req_vld, stay in ARB.
  - SEND: m_vld=1, m_pkt=hold.
    - On m_rdy: ptr<=(w+1) mod N_REQ, go ARB.
- Handshake rules:
  - m_pkt and m_vld are registered and stay stable until m_rdy is sampled high.
  - Transfer occurs on m_vld&m_rdy.
- Latency:
  - Request accepted in cycle t; m_vld rises at t+1.
  - Minimum spacing between grants is 2 cycles, plus however long the sender holds m_rdy low.
- req_rdy:
  - At most one bit high per cycle.
  - Never high in INIT or SEND.
  - Requests not granted stay pending; requesters must hold req_vld and req_pkt.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority next time.
- A requester dropping req_vld before its grant is legal; it is simply skipped.
- m_rdy low in INIT or SEND: hold all outputs indefinitely. There is no timeout.
- Reset mid-transfer: next cycle m_vld=0, then the init table replays from entry 0. The pending hold packet is discarded.
- init_done never clears except on rst.

Optional Feature:
- Macro: SPI_PKT_SCHED_REINIT_EN.
- Defined:
  - A free-running counter counts to REINIT_PERIOD-1, then sets reinit_pend.
  - On the next entry into ARB, reinit_pend takes priority over all req_vld: go INIT with idx=0 and clear reinit_pend.
  - A SEND in progress always completes first.
  - The counter restarts at the start of each init replay.
  - init_done stays 1 during replays.
- Undefined: no counter logic; INIT runs only after rst.

Decomposition:
- Package spi_pkt_sched_pkg:
  - state enum.
  - INIT_MAX=8.
  - INIT_TABLE, an array of INIT_MAX 16-bit entries, defaults 16'h0C01, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00, rest 0.
  - Packet typedef.
- Sub-module rr_arb:
  - Holds the pointer.
  - Inputs: req vector, advance strobe, winner index.
  - Outputs: any and one-hot/binary winner.

Test Plan:
- Init after reset: rst 2 cycles. Model sender holds m_rdy low 40 cycles after each accept. Expect m_pkt sequence 0C01, 0900, 0A08, 0B07, 0F00 each accepted exactly once; then init_done=1; req_rdy=0 throughout.
- Single request: req_vld[1]=1, req_pkt[1]=16'h0305 after init_done. Expect req_rdy[1] pulse 1 cycle, m_vld next cycle with m_pkt=0305, grant_id=1.
- Contention: req_vld=2'b11 continuously with distinct packets 0111 and 0222. Expect grants alternating 0,1,0,1 and packets in that order, with no duplicates or drops.
- Stall: hold m_rdy low 100 cycles during SEND. Expect m_vld=1 and m_pkt unchanged throughout, and no req_rdy pulses.
- Reset mid-SEND: assert rst while m_vld=1 carrying 0222. Expect m_vld=0 next cycle, then init replay starts with 0C01 and 0222 never reappears.
- REINIT_EN build with REINIT_PERIOD=200: requests are continuous. Expect the init sequence to replay after the current SEND completes, the counter to restart, and round-robin order to resume afterwards.
